// File: rtl/sdm_pkg.sv
// -----------------------------------------------------------------------------
// sdm_pkg
// Shared definitions for the sigma-delta modulator feed path: controller state
// encoding, oversampling period helper and the underrun counter width. The
// period helper is also meant for the decimator wrapper so both sides agree
// on the period length.
// -----------------------------------------------------------------------------
package sdm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } sdm_state_e;

  localparam int UNDERRUN_CNT_W = 8;

  // Oversampling period in clocks for a given exponent: 2^(osr+2).
  function automatic int sdm_period(input int osr);
    return 32'sd1 << (osr + 2);
  endfunction

endpackage

// File: rtl/sdm_sample_fifo.sv
// -----------------------------------------------------------------------------
// sdm_sample_fifo
// Small synchronous FIFO holding PCM samples for the feed controller.
// No write-to-read bypass: a sample pushed into an empty FIFO becomes visible
// on o_rdata only after the push edge.
//
// Ports:
//   clk      in   clock
//   rst      in   synchronous active-high reset (empties the FIFO)
//   i_push   in   write i_wdata (ignored when full)
//   i_pop    in   drop the head entry (ignored when empty)
//   i_clear  in   synchronous flush of all entries
//   i_wdata  in   sample to write
//   o_rdata  out  head entry
//   o_count  out  current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module sdm_sample_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_clear,
  input  logic [DATA_W-1:0]        i_wdata,
  output logic [DATA_W-1:0]        o_rdata,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic              w_push;
  logic              w_pop;

  // Fullness is judged on the registered count, so a pop in the same cycle
  // never makes room for a push into a full FIFO.
  assign w_push = i_push && (r_count < (AW+1)'(DEPTH));
  assign w_pop  = i_pop  && (r_count != '0);

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sample storage; contents are don't-care while unoccupied.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/sdm_feed_ctrl.sv
// -----------------------------------------------------------------------------
// sdm_feed_ctrl
// Sequencer in front of the 2nd-order sigma-delta modulator. Buffers incoming
// PCM samples, holds each one on sdm_din for one oversampling period
// (2^(OSR+2) clocks), controls the modulator reset, tracks underruns and
// flushes the loop with mid-scale before stopping.
//
// Ports:
//   clk            in   sole clock
//   rst            in   synchronous active-high reset
//   en             in   run request (level)
//   s_valid/s_data in   upstream sample stream
//   s_ready        out  sample accepted this cycle (decoded)
//   sdm_din        out  modulator input (registered)
//   sdm_rst_n      out  modulator reset, active-low (registered)
//   sample_strobe  out  one-cycle pulse on each sdm_din load (registered)
//   underrun       out  sticky underrun flag (registered)
//   underrun_cnt   out  saturating underrun count (registered)
//   busy           out  controller not idle (decoded)
// -----------------------------------------------------------------------------
module sdm_feed_ctrl
  import sdm_pkg::*;
#(
  parameter int OSR           = 6,
  parameter int DATA_W        = 16,
  parameter int FIFO_DEPTH    = 4,
  parameter int PRIME_LVL     = 2,
  parameter int FLUSH_PERIODS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      s_valid,
  input  logic [DATA_W-1:0]         s_data,
  output logic                      s_ready,
  output logic [DATA_W-1:0]         sdm_din,
  output logic                      sdm_rst_n,
  output logic                      sample_strobe,
  output logic                      underrun,
  output logic [UNDERRUN_CNT_W-1:0] underrun_cnt,
  output logic                      busy
);

  localparam int PH_W  = OSR + 2;
  localparam int P     = sdm_period(OSR);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int FL_W  = $clog2(FLUSH_PERIODS + 1);

  localparam logic [PH_W-1:0]           PH_LAST = PH_W'(P - 1);
  localparam logic [FL_W-1:0]           FL_LAST = FL_W'(FLUSH_PERIODS - 1);
  localparam logic [UNDERRUN_CNT_W-1:0] UR_MAX  = '1;

  sdm_state_e                r_state,     w_state_nxt;
  logic [PH_W-1:0]           r_phase,     w_phase_nxt;
  logic [FL_W-1:0]           r_flush_cnt, w_flush_nxt;
  logic [DATA_W-1:0]         r_sdm_din,   w_din_nxt;
  logic                      r_sdm_rst_n, w_rst_n_nxt;
  logic                      r_strobe,    w_strobe_nxt;
  logic                      r_underrun,  w_ur_nxt;
  logic [UNDERRUN_CNT_W-1:0] r_ur_cnt,    w_ur_cnt_nxt;

  logic              w_s_ready;
  logic              w_push;
  logic              w_pop;
  logic              w_clear;
  logic              w_boundary;
  logic [CNT_W-1:0]  w_count;
  logic [DATA_W-1:0] w_head;

  sdm_sample_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clear (w_clear),
    .i_wdata (s_data),
    .o_rdata (w_head),
    .o_count (w_count)
  );

  assign w_s_ready  = ((r_state == PRIME) || (r_state == RUN)) &&
                      (w_count < CNT_W'(FIFO_DEPTH));
  assign w_push     = s_valid && w_s_ready;
  assign w_boundary = (r_phase == PH_LAST);

  // Next-state and next-output decode.
  always_comb begin
    w_state_nxt  = r_state;
    w_phase_nxt  = r_phase;
    w_flush_nxt  = r_flush_cnt;
    w_din_nxt    = r_sdm_din;
    w_rst_n_nxt  = r_sdm_rst_n;
    w_strobe_nxt = 1'b0;
    w_ur_nxt     = r_underrun;
    w_ur_cnt_nxt = r_ur_cnt;
    w_pop        = 1'b0;
    w_clear      = 1'b0;

    case (r_state)
      IDLE: begin
        w_din_nxt   = '0;
        w_rst_n_nxt = 1'b0;
        w_phase_nxt = '0;
        if (en) begin
          w_state_nxt  = PRIME;
          w_ur_nxt     = 1'b0;
          w_ur_cnt_nxt = '0;
        end else begin
          w_state_nxt = IDLE;
        end
      end

      PRIME: begin
        w_phase_nxt = '0;
        w_rst_n_nxt = 1'b0;
        if (!en) begin
          w_state_nxt = IDLE;
        end else if (w_count >= CNT_W'(PRIME_LVL)) begin
          // Modulator leaves reset on the same edge as its first sample.
          w_pop        = 1'b1;
          w_din_nxt    = w_head;
          w_rst_n_nxt  = 1'b1;
          w_strobe_nxt = 1'b1;
          w_state_nxt  = RUN;
        end else begin
          w_state_nxt = PRIME;
        end
      end

      RUN: begin
        w_phase_nxt = r_phase + PH_W'(1);
        if (w_boundary) begin
          w_strobe_nxt = 1'b1;
          if (!en) begin
            w_din_nxt   = '0;
            w_flush_nxt = '0;
            w_state_nxt = FLUSH;
          end else if (w_count != '0) begin
            w_pop     = 1'b1;
            w_din_nxt = w_head;
          end else begin
            // Starved: keep the previous sample on the loop.
            w_ur_nxt = 1'b1;
            if (r_ur_cnt != UR_MAX) begin
              w_ur_cnt_nxt = r_ur_cnt + UNDERRUN_CNT_W'(1);
            end else begin
              w_ur_cnt_nxt = r_ur_cnt;
            end
          end
        end else begin
          w_strobe_nxt = 1'b0;
        end
      end

      FLUSH: begin
        w_phase_nxt = r_phase + PH_W'(1);
        w_din_nxt   = '0;
        if (w_boundary) begin
          w_strobe_nxt = 1'b1;
          w_flush_nxt  = r_flush_cnt + FL_W'(1);
          if (r_flush_cnt == FL_LAST) begin
            w_rst_n_nxt = 1'b0;
            w_clear     = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = FLUSH;
          end
        end else begin
          w_strobe_nxt = 1'b0;
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_din_nxt   = '0;
        w_rst_n_nxt = 1'b0;
        w_phase_nxt = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_phase     <= '0;
      r_flush_cnt <= '0;
      r_sdm_din   <= '0;
      r_sdm_rst_n <= 1'b0;
      r_strobe    <= 1'b0;
      r_underrun  <= 1'b0;
      r_ur_cnt    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_phase     <= w_phase_nxt;
      r_flush_cnt <= w_flush_nxt;
      r_sdm_din   <= w_din_nxt;
      r_sdm_rst_n <= w_rst_n_nxt;
      r_strobe    <= w_strobe_nxt;
      r_underrun  <= w_ur_nxt;
      r_ur_cnt    <= w_ur_cnt_nxt;
    end
  end

  assign s_ready       = w_s_ready;
  assign sdm_din       = r_sdm_din;
  assign sdm_rst_n     = r_sdm_rst_n;
  assign sample_strobe = r_strobe;
  assign underrun      = r_underrun;
  assign underrun_cnt  = r_ur_cnt;
  assign busy          = (r_state != IDLE);

endmodule

// File: tb/tb_sdm_feed_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sdm_feed_ctrl
// Directed bench for sdm_feed_ctrl. u_dut uses the default OSR=6 (256-clock
// period); u_dut2 uses OSR=0 (4-clock period) so underrun counter saturation
// can be reached in a short run.
// -----------------------------------------------------------------------------
module tb_sdm_feed_ctrl;

  logic        clk = 1'b0;
  logic        rst, en, s_valid;
  logic [15:0] s_data;
  logic        s_ready, sdm_rst_n, sample_strobe, underrun, busy;
  logic [15:0] sdm_din;
  logic [7:0]  underrun_cnt;

  logic        en2, s_valid2;
  logic [15:0] s_data2;
  logic        s_ready2, sdm_rst_n2, sample_strobe2, underrun2, busy2;
  logic [15:0] sdm_din2;
  logic [7:0]  underrun_cnt2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sdm_feed_ctrl u_dut (
    .clk(clk), .rst(rst), .en(en), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .sdm_din(sdm_din), .sdm_rst_n(sdm_rst_n),
    .sample_strobe(sample_strobe), .underrun(underrun),
    .underrun_cnt(underrun_cnt), .busy(busy)
  );

  sdm_feed_ctrl #(.OSR(0)) u_dut2 (
    .clk(clk), .rst(rst), .en(en2), .s_valid(s_valid2), .s_data(s_data2),
    .s_ready(s_ready2), .sdm_din(sdm_din2), .sdm_rst_n(sdm_rst_n2),
    .sample_strobe(sample_strobe2), .underrun(underrun2),
    .underrun_cnt(underrun_cnt2), .busy(busy2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance until the next strobe (bounded) and check the cycle distance.
  task automatic wait_strobe(input string tag, input int exp_n);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (sample_strobe !== 1'b1 && n < 600);
    chk(tag, n, exp_n);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_din"},    sdm_din, 32'h0);
    chk({tag, "_rstn"},   sdm_rst_n, 32'h0);
    chk({tag, "_ready"},  s_ready, 32'h0);
    chk({tag, "_strobe"}, sample_strobe, 32'h0);
    chk({tag, "_ur"},     underrun, 32'h0);
    chk({tag, "_urcnt"},  underrun_cnt, 32'h0);
    chk({tag, "_busy"},   busy, 32'h0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; s_valid = 1'b0; s_data = 16'h0000;
    en2 = 1'b0; s_valid2 = 1'b0; s_data2 = 16'h0000;
    tick(); tick();
    chk_reset_vals("por");
    rst = 1'b0;
    repeat (3) tick();
    chk("idle_ready", s_ready, 32'h0);

    // Prime with two samples, then run.
    en = 1'b1;
    tick();
    chk("prime_busy", busy, 32'h1);
    chk("prime_ready", s_ready, 32'h1);
    s_valid = 1'b1; s_data = 16'h1000; tick();
    s_data = 16'hF000; tick();
    s_valid = 1'b0;
    chk("prime_rstn_low", sdm_rst_n, 32'h0);
    tick();
    chk("run_din0", sdm_din, 32'h1000);
    chk("run_rstn", sdm_rst_n, 32'h1);
    chk("run_strobe0", sample_strobe, 32'h1);
    repeat (255) tick();
    chk("hold_din", sdm_din, 32'h1000);
    chk("hold_strobe", sample_strobe, 32'h0);
    tick();
    chk("bnd1_din", sdm_din, 32'hF000);
    chk("bnd1_strobe", sample_strobe, 32'h1);
    chk("bnd1_ur", underrun, 32'h0);

    // Underrun: nothing queued.
    wait_strobe("ur_period", 256);
    chk("ur_din", sdm_din, 32'hF000);
    chk("ur_flag", underrun, 32'h1);
    chk("ur_cnt", underrun_cnt, 32'h1);

    // Backpressure: fill to 4, keep offering 0x0005.
    s_valid = 1'b1;
    s_data = 16'h0001; tick();
    s_data = 16'h0002; tick();
    s_data = 16'h0003; tick();
    s_data = 16'h0004; tick();
    s_data = 16'h0005;
    chk("bp_full_ready", s_ready, 32'h0);
    wait_strobe("bp_bnd", 252);
    chk("bp_din1", sdm_din, 32'h0001);
    chk("bp_reopen", s_ready, 32'h1);
    tick();
    s_valid = 1'b0;
    chk("bp_refull", s_ready, 32'h0);
    wait_strobe("bp_p2", 255);
    chk("bp_din2", sdm_din, 32'h0002);
    wait_strobe("bp_p3", 256);
    chk("bp_din3", sdm_din, 32'h0003);
    wait_strobe("bp_p4", 256);
    chk("bp_din4", sdm_din, 32'h0004);
    wait_strobe("bp_p5", 256);
    chk("bp_din5", sdm_din, 32'h0005);

    // Stop at phase 100, then flush.
    repeat (100) tick();
    en = 1'b0;
    repeat (155) tick();
    chk("stop_hold_din", sdm_din, 32'h0005);
    chk("stop_hold_strobe", sample_strobe, 32'h0);
    tick();
    chk("flush_strobe", sample_strobe, 32'h1);
    chk("flush_din", sdm_din, 32'h0);
    chk("flush_rstn", sdm_rst_n, 32'h1);
    chk("flush_ready", s_ready, 32'h0);
    chk("flush_urcnt", underrun_cnt, 32'h1);
    repeat (5) tick();
    en = 1'b1;
    wait_strobe("flush_p1", 251);
    chk("flush_p1_din", sdm_din, 32'h0);
    wait_strobe("flush_p2", 256);
    wait_strobe("flush_p3", 256);
    chk("flush_p3_rstn", sdm_rst_n, 32'h1);
    chk("flush_p3_busy", busy, 32'h1);
    wait_strobe("flush_p4", 256);
    chk("flush_end_rstn", sdm_rst_n, 32'h0);
    chk("flush_end_busy", busy, 32'h0);
    chk("flush_end_din", sdm_din, 32'h0);
    tick();
    chk("reprime_busy", busy, 32'h1);
    chk("reprime_ur", underrun, 32'h0);
    chk("reprime_urcnt", underrun_cnt, 32'h0);

    // Boundary collision: push into empty FIFO on the last-phase cycle.
    s_valid = 1'b1; s_data = 16'h1111; tick();
    s_data = 16'h2222; tick();
    s_valid = 1'b0; tick();
    chk("col_din0", sdm_din, 32'h1111);
    wait_strobe("col_p1", 256);
    chk("col_din1", sdm_din, 32'h2222);
    repeat (255) tick();
    s_valid = 1'b1; s_data = 16'h3333; tick();
    s_valid = 1'b0;
    chk("col_strobe", sample_strobe, 32'h1);
    chk("col_hold", sdm_din, 32'h2222);
    chk("col_urcnt", underrun_cnt, 32'h1);
    wait_strobe("col_p2", 256);
    chk("col_load", sdm_din, 32'h3333);
    chk("col_urcnt2", underrun_cnt, 32'h1);

    // Reset mid-RUN with a sample pending in the FIFO.
    s_valid = 1'b1; s_data = 16'h4444; tick();
    s_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b1; en = 1'b0; tick();
    rst = 1'b0;
    chk_reset_vals("midrst");
    repeat (3) tick();
    chk("midrst_ready", s_ready, 32'h0);
    en = 1'b1; tick();
    chk("midrst_prime_ready", s_ready, 32'h1);
    s_valid = 1'b1; s_data = 16'h5555; tick();
    s_data = 16'h6666; tick();
    s_valid = 1'b0; tick();
    chk("midrst_discard", sdm_din, 32'h5555);

    // Saturation on the short-period instance.
    en2 = 1'b1; tick();
    s_valid2 = 1'b1; s_data2 = 16'h0AAA; tick();
    s_data2 = 16'h0BBB; tick();
    s_valid2 = 1'b0; tick();
    chk("sat_din0", sdm_din2, 32'h0AAA);
    repeat (8) tick();
    chk("sat_first", underrun_cnt2, 32'h1);
    chk("sat_din_hold", sdm_din2, 32'h0BBB);
    repeat (1200) tick();
    chk("sat_cnt", underrun_cnt2, 32'hFF);
    chk("sat_flag", underrun2, 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
